// File: rtl/l1_d_l2_if_pkg.sv
// Shared widths and FSM encoding for the L1 data cache to L2 line-transfer interface.
package l1_d_l2_if_pkg;

  localparam int LINE_W = 512;
  localparam int WORD_W = 32;
  localparam int OFF_W  = 6;
  localparam int TAG_W  = 21;
  localparam int IDX_W  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } l2_state_e;

endpackage

// File: rtl/l1_d_l2_if.sv
// Moves one cache line between the L1 D controller and a word-wide bus:
// a write-back streams the victim line out, a refill gathers the line beat by beat.
module l1_d_l2_if
  import l1_d_l2_if_pkg::*;
#(
  parameter int LINE_W = l1_d_l2_if_pkg::LINE_W,
  parameter int WORD_W = l1_d_l2_if_pkg::WORD_W,
  parameter int OFF_W  = l1_d_l2_if_pkg::OFF_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_L1_L2,
  input  logic              write_L1_L2,
  input  logic [IDX_W-1:0]  index_L1_L2,
  input  logic [TAG_W-1:0]  tag_L1_L2,
  input  logic [TAG_W-1:0]  write_tag_L1_L2,
  input  logic [LINE_W-1:0] wdata_line,
  output logic              ready_L2_L1,
  output logic [LINE_W-1:0] rdata_line,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [31:0]       bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [WORD_W-1:0] bus_rdata,
  output l2_state_e         state_dbg
);

  localparam int BEATS   = LINE_W / WORD_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SH = $clog2(WORD_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  l2_state_e         state_q, state_d;
  logic              prev_rd_q, prev_wr_q;
  logic              rd_flag_q, wr_flag_q;
  logic [CNT_W-1:0]  beat_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wline_q, rline_q;
  logic              ready_q;
  logic              rd_edge, wr_edge, rd_req, wr_req, bus_hs, last_beat;

  // Edges seen while busy are parked in the flags and served on return to IDLE.
  assign rd_edge   = read_L1_L2 & ~prev_rd_q;
  assign wr_edge   = write_L1_L2 & ~prev_wr_q;
  assign wr_req    = wr_edge | wr_flag_q;
  assign rd_req    = rd_edge | rd_flag_q;
  // A beat transfers on a cycle where bus_valid and bus_ready are both high;
  // once bus_valid rises, address/we/data hold until that cycle.
  assign bus_hs    = bus_valid & bus_ready;
  assign last_beat = (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_req)      state_d = WR_REQ;
        else if (rd_req) state_d = RD_REQ;
      end
      WR_REQ:  if (bus_hs && last_beat) state_d = DONE;
      RD_REQ:  if (bus_hs) state_d = RD_WAIT;
      RD_WAIT: if (bus_rvalid) state_d = last_beat ? DONE : RD_REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (state_q == WR_REQ || state_q == RD_REQ) begin
      bus_valid = 1'b1;
      bus_addr  = 32'({tag_q, idx_q, {OFF_W{1'b0}}}) + (32'(beat_q) << BYTE_SH);
    end
    if (state_q == WR_REQ) begin
      bus_we    = 1'b1;
      bus_wdata = wline_q[beat_q * WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_rd_q <= 1'b0;
      prev_wr_q <= 1'b0;
      rd_flag_q <= 1'b0;
      wr_flag_q <= 1'b0;
      beat_q    <= '0;
      tag_q     <= '0;
      idx_q     <= '0;
      wline_q   <= '0;
      rline_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      prev_rd_q <= read_L1_L2;
      prev_wr_q <= write_L1_L2;
      ready_q   <= (state_d == DONE);
      if (state_q == IDLE) begin
        wr_flag_q <= 1'b0;
        // A parked read survives a write accept; a read edge coinciding with it is dropped.
        rd_flag_q <= wr_req & rd_flag_q;
        if (wr_req) begin
          tag_q   <= write_tag_L1_L2;
          idx_q   <= index_L1_L2;
          wline_q <= wdata_line;
          beat_q  <= '0;
        end else if (rd_req) begin
          tag_q  <= tag_L1_L2;
          idx_q  <= index_L1_L2;
          beat_q <= '0;
        end
      end else begin
        if (wr_edge) wr_flag_q <= 1'b1;
        if (rd_edge) rd_flag_q <= 1'b1;
      end
      if (state_q == WR_REQ && bus_hs) beat_q <= beat_q + 1'b1;
      if (state_q == RD_WAIT && bus_rvalid) begin
        rline_q[beat_q * WORD_W +: WORD_W] <= bus_rdata;
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign ready_L2_L1 = ready_q;
  assign rdata_line  = rline_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_l1_d_l2_if.sv
// Directed bench for l1_d_l2_if: table of line transfers plus hand-written
// sequences for level-held requests, back-to-back, coincident edges and reset abort.
module tb_l1_d_l2_if;
  import l1_d_l2_if_pkg::*;

  localparam int LW = 512;
  localparam int WW = 32;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          read_L1_L2 = 1'b0, write_L1_L2 = 1'b0;
  logic [4:0]    index_L1_L2 = '0;
  logic [20:0]   tag_L1_L2 = '0, write_tag_L1_L2 = '0;
  logic [LW-1:0] wdata_line = '0;
  logic          ready_L2_L1;
  logic [LW-1:0] rdata_line;
  logic          bus_valid, bus_we;
  logic          bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0]   bus_addr;
  logic [WW-1:0] bus_wdata, bus_rdata = '0;
  l2_state_e     state_dbg;

  l1_d_l2_if dut (
    .clk(clk), .nrst(nrst), .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2),
    .index_L1_L2(index_L1_L2), .tag_L1_L2(tag_L1_L2), .write_tag_L1_L2(write_tag_L1_L2),
    .wdata_line(wdata_line), .ready_L2_L1(ready_L2_L1), .rdata_line(rdata_line),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus model and monitor ----------------
  int          stall = 0;
  logic [31:0] rd_seed = '0;
  logic        spur_rvalid = 1'b0;
  logic [64:0] hs_log[$];
  int          ready_cnt = 0, ready_cyc = 0;
  int          stab_bad = 0, stab_checks = 0;

  initial begin : bus_model
    int          wait_cnt;
    logic        rd_pend, prev_stall;
    logic [31:0] rd_addr;
    logic [64:0] snap, cur;
    wait_cnt = 0; rd_pend = 1'b0; prev_stall = 1'b0; rd_addr = '0; snap = '0;
    forever begin
      @(negedge clk);
      cur = {bus_we, bus_addr, bus_wdata};
      if (!nrst) begin
        rd_pend = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus_valid) begin
          stab_checks++;
          if (cur !== snap) stab_bad++;
        end
        prev_stall = bus_valid && !bus_ready;
        snap = cur;
        if (bus_valid && bus_ready) begin
          hs_log.push_back(cur);
          if (!bus_we) begin rd_pend = 1'b1; rd_addr = bus_addr; end
        end
        if (ready_L2_L1) begin ready_cnt++; ready_cyc = cyc; end
      end
      @(posedge clk); #1;
      if (!nrst) begin
        bus_ready = 1'b0; bus_rvalid = 1'b0; wait_cnt = 0;
      end else begin
        bus_rvalid = rd_pend | spur_rvalid;
        bus_rdata  = rd_pend ? rd_seed + 32'(rd_addr[5:2]) : 32'hDEAD_BEEF;
        rd_pend    = 1'b0;
        if (bus_valid) begin
          if (wait_cnt >= stall) begin bus_ready = 1'b1; wait_cnt = 0; end
          else begin bus_ready = 1'b0; wait_cnt++; end
        end else begin
          bus_ready = 1'b0; wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic [64:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_line(input bit wr, input logic [31:0] first, input logic [31:0] seed);
    for (int k = 0; k < NB; k++)
      exp_q.push_back({wr, first + 32'(4 * k), wr ? seed + 32'(k) : 32'h0});
  endtask

  task automatic score(input int hs0, input string name);
    int n;
    logic [64:0] e;
    n = hs_log.size() - hs0;
    check({name, "_beats"}, n, exp_q.size());
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      check({name, "_beat"}, hs_log[hs0 + i], e);
    end
    exp_q.delete();
  endtask

  task automatic wait_ready(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (ready_cnt < target && n < budget) begin tick(1); n++; end
    check({name, "_ready_seen"}, ready_cnt >= target, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [20:0] tag;
    logic [4:0]  idx;
    int          stall;
    logic [31:0] seed;
    logic [31:0] first_addr;
    logic [31:0] last_addr;
    int          lat;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string name);
    int hs0, r0, c0, nw;
    hs0 = hs_log.size(); r0 = ready_cnt;
    stall = v.stall; rd_seed = v.seed;
    for (int k = 0; k < NB; k++) wdata_line[k*WW +: WW] = v.seed + 32'(k);
    index_L1_L2 = v.idx;
    if (v.wr) begin write_tag_L1_L2 = v.tag; tag_L1_L2 = 21'h0F0F0; end
    else begin tag_L1_L2 = v.tag; write_tag_L1_L2 = 21'h0F0F0; end
    push_line(v.wr, v.first_addr, v.seed);
    if (v.wr) write_L1_L2 = 1'b1; else read_L1_L2 = 1'b1;
    c0 = cyc;
    tick(1);
    // inputs change after acceptance and must not leak into the transfer
    tag_L1_L2 = 21'($urandom); write_tag_L1_L2 = 21'($urandom); index_L1_L2 = 5'($urandom);
    for (int k = 0; k < NB; k++) wdata_line[k*WW +: WW] = $urandom;
    wait_ready(r0 + 1, 200, name);
    check({name, "_latency"}, ready_cyc - c0, v.lat);
    read_L1_L2 = 1'b0; write_L1_L2 = 1'b0;
    tick(3);
    check({name, "_ready_pulses"}, ready_cnt - r0, 1);
    if (hs_log.size() - hs0 >= NB) begin
      check({name, "_first_addr"}, hs_log[hs0][63:32], v.first_addr);
      check({name, "_last_addr"}, hs_log[hs0 + NB - 1][63:32], v.last_addr);
    end
    score(hs0, name);
    if (!v.wr) begin
      nw = 0;
      for (int k = 0; k < NB; k++) if (rdata_line[k*WW +: WW] !== v.seed + 32'(k)) nw++;
      check({name, "_rline_bad_words"}, nw, 0);
    end
    check({name, "_idle_after"}, {bus_valid, state_dbg}, {1'b0, IDLE});
  endtask

  // ---------------- test ----------------
  initial begin : test
    int hs0, r0, n;
    logic [LW-1:0] snap_line;

    vecs[0] = '{1'b0, 21'h000ABC, 5'd5,  0, 32'h0,    32'h0055E140, 32'h0055E17C, 33};
    vecs[1] = '{1'b1, 21'h1FFFFF, 5'd31, 2, 32'hA0,   32'hFFFFFFC0, 32'hFFFFFFFC, 49};
    vecs[2] = '{1'b1, 21'h000000, 5'd0,  0, 32'h1000, 32'h00000000, 32'h0000003C, 17};
    vecs[3] = '{1'b0, 21'h012345, 5'd10, 1, 32'h5500, 32'h091A2A80, 32'h091A2ABC, 49};

    tick(3);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_ready", ready_L2_L1, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_we_wdata", {bus_we, bus_wdata}, 0);
    check("rst_rdata_zero", |rdata_line, 0);
    check("rst_state", state_dbg, IDLE);
    nrst = 1'b1;
    tick(2);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) check("vec1_stall_seen", stab_checks > 0, 1);
    end
    check("stall_stable", stab_bad, 0);

    // stray read data while idle must not disturb the held line
    snap_line = rdata_line;
    spur_rvalid = 1'b1; tick(2); spur_rvalid = 1'b0; tick(2);
    check("spur_rvalid_line", rdata_line === snap_line, 1);
    check("spur_rvalid_state", state_dbg, IDLE);

    // read level held for 40 cycles
    stall = 0; rd_seed = 32'h300;
    hs0 = hs_log.size(); r0 = ready_cnt;
    tag_L1_L2 = 21'h00001; index_L1_L2 = 5'd2;
    push_line(1'b0, 32'h00000880, 32'h0);
    read_L1_L2 = 1'b1; tick(40); read_L1_L2 = 1'b0; tick(5);
    check("held_ready_pulses", ready_cnt - r0, 1);
    score(hs0, "held");

    // write-back then allocate, read edge one cycle behind
    hs0 = hs_log.size(); r0 = ready_cnt;
    write_tag_L1_L2 = 21'h00002; tag_L1_L2 = 21'h00003; index_L1_L2 = 5'd1;
    for (int k = 0; k < NB; k++) wdata_line[k*WW +: WW] = 32'h700 + 32'(k);
    push_line(1'b1, 32'h00001040, 32'h700);
    push_line(1'b0, 32'h00001840, 32'h0);
    write_L1_L2 = 1'b1; tick(1); read_L1_L2 = 1'b1;
    wait_ready(r0 + 2, 300, "b2b");
    tick(20); write_L1_L2 = 1'b0; read_L1_L2 = 1'b0; tick(5);
    check("b2b_ready_pulses", ready_cnt - r0, 2);
    score(hs0, "b2b");

    // coincident edges: write wins, read is lost
    hs0 = hs_log.size(); r0 = ready_cnt;
    write_tag_L1_L2 = 21'h00004; tag_L1_L2 = 21'h00005; index_L1_L2 = 5'd3;
    for (int k = 0; k < NB; k++) wdata_line[k*WW +: WW] = 32'h900 + 32'(k);
    push_line(1'b1, 32'h000020C0, 32'h900);
    write_L1_L2 = 1'b1; read_L1_L2 = 1'b1;
    wait_ready(r0 + 1, 200, "both");
    tick(50); write_L1_L2 = 1'b0; read_L1_L2 = 1'b0; tick(3);
    check("both_ready_pulses", ready_cnt - r0, 1);
    score(hs0, "both");

    // reset during beat 7 of a refill
    hs0 = hs_log.size(); r0 = ready_cnt;
    tag_L1_L2 = 21'h00006; index_L1_L2 = 5'd4;
    read_L1_L2 = 1'b1;
    n = 0;
    while (hs_log.size() - hs0 < 7 && n < 200) begin tick(1); n++; end
    check("abort_reached_beat7", hs_log.size() - hs0, 7);
    #2 nrst = 1'b0;
    #1;
    check("abort_bus_valid", bus_valid, 0);
    check("abort_bus_addr", bus_addr, 0);
    check("abort_rdata_zero", |rdata_line, 0);
    check("abort_state", state_dbg, IDLE);
    read_L1_L2 = 1'b0;
    tick(2); nrst = 1'b1; tick(20);
    check("abort_no_reissue", hs_log.size() - hs0, 7);
    check("abort_no_ready", ready_cnt - r0, 0);
    run_vec(vecs[0], "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
